// File: rtl/pipeline_deliver_multi.sv
// pipeline_deliver_multi
//   Multi-lane deliver stage between the PC/branch-predictor stage and fetch.
//   LANES instruction slots (PC plus prediction payload) travel together through
//   DEPTH register stages. Lane 0 is the oldest slot in a group. A kill on a lane
//   also kills every younger lane. A saturating counter records each bubble
//   (all lanes invalid) that is loaded into the last stage.
//
// Parameters
//   WIDTH      payload bits per lane
//   LANES      parallel slots per group
//   DEPTH      register stages, legal range 1..4
//   CNT_WIDTH  bubble counter width
//
// Ports
//   clk                  clock, rising edge
//   rst                  synchronous active-high reset
//   flush                clear all stages (bubble counter untouched)
//   stall_current_stage  producer stalled: stage 0 takes a bubble, later stages shift
//   stall_next_stage     consumer stalled: every stage holds
//   valid_in  [LANES]    per-lane valid of the incoming group
//   kill_in   [LANES]    per-lane kill of the incoming group
//   data_in   [LANES*WIDTH]  lane i at [i*WIDTH +: WIDTH]
//   valid_out [LANES]    per-lane valid of the last stage
//   data_out  [LANES*WIDTH]  payload of the last stage; invalid lanes read as 0
//   bubble_count [CNT_WIDTH] saturating count of bubbles delivered to the last stage
module pipeline_deliver_multi #(
  parameter int WIDTH     = 32,
  parameter int LANES     = 2,
  parameter int DEPTH     = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   stall_current_stage,
  input  logic                   stall_next_stage,
  input  logic [LANES-1:0]       valid_in,
  input  logic [LANES-1:0]       kill_in,
  input  logic [LANES*WIDTH-1:0] data_in,
  output logic [LANES-1:0]       valid_out,
  output logic [LANES*WIDTH-1:0] data_out,
  output logic [CNT_WIDTH-1:0]   bubble_count
);

  logic [LANES-1:0]       stage_valid [DEPTH];
  logic [LANES*WIDTH-1:0] stage_data  [DEPTH];

  logic                   killed;
  logic [LANES-1:0]       alive;
  logic [LANES*WIDTH-1:0] eff_data;
  logic [LANES-1:0]       s0_valid;
  logic [LANES*WIDTH-1:0] s0_data;
  logic [LANES-1:0]       last_valid_next;
  logic                   bubble_in;

  // In-order kill: once any lane at or below i is killed, lane i and all
  // younger lanes are dead. Dead lanes carry zero data so that invalid output
  // lanes always read as zero.
  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    killed   = 1'b0;
    alive    = '0;
    eff_data = '0;
    for (int i = 0; i < LANES; i++) begin
      killed   = killed | kill_in[i];
      alive[i] = valid_in[i] & ~killed;
      if (alive[i]) eff_data[i*WIDTH +: WIDTH] = data_in[i*WIDTH +: WIDTH];
    end
  end

  // Stage 0 takes a bubble while the producer is stalled.
  assign s0_valid = stall_current_stage ? '0 : alive;
  assign s0_data  = stall_current_stage ? '0 : eff_data;

  // Value the last stage would take on a loading edge; used for bubble counting.
  generate
    if (DEPTH == 1) begin : g_last_from_input
      assign last_valid_next = s0_valid;
    end else begin : g_last_from_stage
      assign last_valid_next = stage_valid[DEPTH-2];
    end
  endgenerate

  assign bubble_in = ~|last_valid_next;

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the pre-edge value of its predecessor, giving a true shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the stage array is reset explicitly because the outputs must read
      // as zero from the first reset edge; it is only DEPTH words, not a RAM.
      for (int k = 0; k < DEPTH; k++) begin
        stage_valid[k] <= '0;
        stage_data[k]  <= '0;
      end
      bubble_count <= '0;
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_valid[k] <= '0;
        stage_data[k]  <= '0;
      end
    end else if (!stall_next_stage) begin
      stage_valid[0] <= s0_valid;
      stage_data[0]  <= s0_data;
      for (int k = 1; k < DEPTH; k++) begin
        stage_valid[k] <= stage_valid[k-1];
        stage_data[k]  <= stage_data[k-1];
      end
      if (bubble_in && (bubble_count != '1)) begin
        bubble_count <= bubble_count + CNT_WIDTH'(1);
      end
    end
  end

  assign valid_out = stage_valid[DEPTH-1];
  assign data_out  = stage_data[DEPTH-1];

endmodule

// File: tb/tb_pipeline_deliver_multi.sv
// Bench for pipeline_deliver_multi. Two instances share the input stimulus:
//   dut_a: DEPTH=2, CNT_WIDTH=16
//   dut_b: DEPTH=1, CNT_WIDTH=4 (used for saturation)
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_pipeline_deliver_multi;

  localparam int WIDTH = 32;
  localparam int LANES = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush;
  logic                   stall_current_stage;
  logic                   stall_next_stage;
  logic [LANES-1:0]       valid_in;
  logic [LANES-1:0]       kill_in;
  logic [LANES*WIDTH-1:0] data_in;

  logic [LANES-1:0]       valid_a, valid_b;
  logic [LANES*WIDTH-1:0] data_a, data_b;
  logic [15:0]            count_a;
  logic [3:0]             count_b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [LANES-1:0]       v;
    logic [LANES*WIDTH-1:0] d;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [15:0] exp_cnt_a;
  logic [3:0]  exp_cnt_b;

  always #5 clk = ~clk;

  pipeline_deliver_multi #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(2), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .stall_current_stage(stall_current_stage), .stall_next_stage(stall_next_stage),
    .valid_in(valid_in), .kill_in(kill_in), .data_in(data_in),
    .valid_out(valid_a), .data_out(data_a), .bubble_count(count_a)
  );

  pipeline_deliver_multi #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(1), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .stall_current_stage(stall_current_stage), .stall_next_stage(stall_next_stage),
    .valid_in(valid_in), .kill_in(kill_in), .data_in(data_in),
    .valid_out(valid_b), .data_out(data_b), .bubble_count(count_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; flush = 1'b0; stall_current_stage = 1'b0; stall_next_stage = 1'b0;
    valid_in = '0; kill_in = '0; data_in = '0;
  endtask

  // Expected group after the in-order kill rule.
  function automatic exp_t expect_group(input logic [LANES-1:0] v, input logic [LANES-1:0] k,
                                        input logic [LANES*WIDTH-1:0] d);
    exp_t e;
    logic dead;
    dead = 1'b0;
    e.v  = '0;
    e.d  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (k[i]) dead = 1'b1;
      if (v[i] && !dead) begin
        e.v[i] = 1'b1;
        e.d[i*WIDTH +: WIDTH] = d[i*WIDTH +: WIDTH];
      end
    end
    return e;
  endfunction

  // Reset both instances and reprime the scoreboards: dut_a's last stage shows
  // the reset bubble for one edge before the first driven group arrives.
  task automatic do_reset();
    exp_t z;
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    z.v = '0; z.d = '0;
    q_a.delete(); q_b.delete();
    q_a.push_back(z);
    exp_cnt_a = '0;
    exp_cnt_b = '0;
  endtask

  // Drive one advancing group; push expectations, then pop and compare.
  task automatic drive_sb(input logic [LANES-1:0] v, input logic [LANES-1:0] k,
                          input logic [LANES*WIDTH-1:0] d, input string tag);
    exp_t e, ea, eb;
    e = expect_group(v, k, d);
    valid_in = v; kill_in = k; data_in = d;
    q_a.push_back(e);
    q_b.push_back(e);
    step();
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    if (ea.v == '0 && exp_cnt_a != 16'hffff) exp_cnt_a++;
    if (eb.v == '0 && exp_cnt_b != 4'hf) exp_cnt_b++;
    n_checks += 6;
    if (valid_a !== ea.v) begin n_fail++; $display("FAIL %s valid_a got %b exp %b", tag, valid_a, ea.v); end
    if (data_a !== ea.d) begin n_fail++; $display("FAIL %s data_a got %h exp %h", tag, data_a, ea.d); end
    if (count_a !== exp_cnt_a) begin n_fail++; $display("FAIL %s count_a got %0d exp %0d", tag, count_a, exp_cnt_a); end
    if (valid_b !== eb.v) begin n_fail++; $display("FAIL %s valid_b got %b exp %b", tag, valid_b, eb.v); end
    if (data_b !== eb.d) begin n_fail++; $display("FAIL %s data_b got %h exp %h", tag, data_b, eb.d); end
    if (count_b !== exp_cnt_b) begin n_fail++; $display("FAIL %s count_b got %0d exp %0d", tag, count_b, exp_cnt_b); end
  endtask

  task automatic test_reset();
    idle_inputs();
    valid_in = 2'b11; data_in = {32'hdead_beef, 32'h1234_5678};
    rst = 1'b1; stall_next_stage = 1'b1;
    step();
    n_checks += 6;
    if (valid_a !== 2'b00) begin n_fail++; $display("FAIL reset valid_a got %b exp 00", valid_a); end
    if (data_a !== '0) begin n_fail++; $display("FAIL reset data_a got %h exp 0", data_a); end
    if (count_a !== 16'd0) begin n_fail++; $display("FAIL reset count_a got %0d exp 0", count_a); end
    if (valid_b !== 2'b00) begin n_fail++; $display("FAIL reset valid_b got %b exp 00", valid_b); end
    if (data_b !== '0) begin n_fail++; $display("FAIL reset data_b got %h exp 0", data_b); end
    if (count_b !== 4'd0) begin n_fail++; $display("FAIL reset count_b got %0d exp 0", count_b); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 3; c++)
      drive_sb(2'b11, 2'b00, {32'h0000_2000 + 32'(c), 32'h0000_1000 + 32'(c)}, "reset_mid_fill");
    valid_in = 2'b11; data_in = {32'h5555_5555, 32'haaaa_aaaa};
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks += 3;
    if (valid_a !== 2'b00) begin n_fail++; $display("FAIL reset_mid valid_a got %b exp 00", valid_a); end
    if (data_a !== '0) begin n_fail++; $display("FAIL reset_mid data_a got %h exp 0", data_a); end
    if (count_a !== 16'd0) begin n_fail++; $display("FAIL reset_mid count_a got %0d exp 0", count_a); end
  endtask

  task automatic test_latency();
    do_reset();
    valid_in = 2'b11; data_in = {32'h0000_1004, 32'h0000_1000};
    step();
    n_checks += 3;
    if (valid_a !== 2'b00) begin n_fail++; $display("FAIL latency_early valid_a got %b exp 00", valid_a); end
    if (valid_b !== 2'b11) begin n_fail++; $display("FAIL latency_d1 valid_b got %b exp 11", valid_b); end
    if (data_b !== {32'h0000_1004, 32'h0000_1000}) begin n_fail++; $display("FAIL latency_d1 data_b got %h", data_b); end
    valid_in = 2'b00; data_in = '0;
    step();
    n_checks += 2;
    if (valid_a !== 2'b11) begin n_fail++; $display("FAIL latency_d2 valid_a got %b exp 11", valid_a); end
    if (data_a !== {32'h0000_1004, 32'h0000_1000}) begin n_fail++; $display("FAIL latency_d2 data_a got %h", data_a); end
  endtask

  task automatic test_kill();
    do_reset();
    drive_sb(2'b11, 2'b01, {32'h0000_1004, 32'h0000_1000}, "kill_lane0");
    drive_sb(2'b11, 2'b10, {32'h0000_1004, 32'h0000_1000}, "kill_lane1");
    drive_sb(2'b10, 2'b00, {32'h0000_2004, 32'h0000_2000}, "young_only");
    drive_sb(2'b11, 2'b11, {32'h0000_3004, 32'h0000_3000}, "kill_both");
    drive_sb(2'b00, 2'b00, '0, "kill_drain");
    // Direct check of the lane1-kill result on the single-stage instance.
    valid_in = 2'b11; kill_in = 2'b10; data_in = {32'h0000_1004, 32'h0000_1000};
    step();
    n_checks += 2;
    if (valid_b !== 2'b01) begin n_fail++; $display("FAIL kill_direct valid_b got %b exp 01", valid_b); end
    if (data_b !== {32'h0, 32'h0000_1000}) begin n_fail++; $display("FAIL kill_direct data_b got %h", data_b); end
    kill_in = '0;
  endtask

  task automatic test_stall();
    logic [63:0] d1;
    d1 = {32'h0000_4004, 32'h0000_4000};
    do_reset();
    valid_in = 2'b11; data_in = d1;
    step();
    stall_next_stage = 1'b1;
    for (int c = 0; c < 3; c++) begin
      data_in = {$urandom, $urandom};
      kill_in = 2'($urandom);
      step();
      n_checks += 4;
      if (valid_b !== 2'b11) begin n_fail++; $display("FAIL stall_hold valid_b got %b exp 11", valid_b); end
      if (data_b !== d1) begin n_fail++; $display("FAIL stall_hold data_b got %h exp %h", data_b, d1); end
      if (count_b !== 4'd0) begin n_fail++; $display("FAIL stall_hold count_b got %0d exp 0", count_b); end
      if (count_a !== 16'd1) begin n_fail++; $display("FAIL stall_hold count_a got %0d exp 1", count_a); end
    end
    stall_next_stage = 1'b0; stall_current_stage = 1'b1; kill_in = '0;
    valid_in = 2'b11; data_in = {32'h0000_5004, 32'h0000_5000};
    step();
    stall_current_stage = 1'b0;
    n_checks += 6;
    if (valid_b !== 2'b00) begin n_fail++; $display("FAIL stall_cur valid_b got %b exp 00", valid_b); end
    if (data_b !== '0) begin n_fail++; $display("FAIL stall_cur data_b got %h exp 0", data_b); end
    if (count_b !== 4'd1) begin n_fail++; $display("FAIL stall_cur count_b got %0d exp 1", count_b); end
    if (valid_a !== 2'b11) begin n_fail++; $display("FAIL stall_cur_shift valid_a got %b exp 11", valid_a); end
    if (data_a !== d1) begin n_fail++; $display("FAIL stall_cur_shift data_a got %h exp %h", data_a, d1); end
    if (count_a !== 16'd1) begin n_fail++; $display("FAIL stall_cur_shift count_a got %0d exp 1", count_a); end
  endtask

  task automatic test_flush();
    do_reset();
    drive_sb(2'b11, 2'b00, {32'h0000_6004, 32'h0000_6000}, "flush_fill1");
    drive_sb(2'b11, 2'b00, {32'h0000_7004, 32'h0000_7000}, "flush_fill2");
    flush = 1'b1; stall_next_stage = 1'b1;
    valid_in = 2'b11; data_in = {32'h0000_8004, 32'h0000_8000};
    step();
    flush = 1'b0; stall_next_stage = 1'b0;
    n_checks += 6;
    if (valid_a !== 2'b00) begin n_fail++; $display("FAIL flush valid_a got %b exp 00", valid_a); end
    if (data_a !== '0) begin n_fail++; $display("FAIL flush data_a got %h exp 0", data_a); end
    if (count_a !== 16'd1) begin n_fail++; $display("FAIL flush count_a got %0d exp 1", count_a); end
    if (valid_b !== 2'b00) begin n_fail++; $display("FAIL flush valid_b got %b exp 00", valid_b); end
    if (data_b !== '0) begin n_fail++; $display("FAIL flush data_b got %h exp 0", data_b); end
    if (count_b !== 4'd0) begin n_fail++; $display("FAIL flush count_b got %0d exp 0", count_b); end
    // Stage 0 of dut_a was cleared too, so the next advance delivers a bubble.
    valid_in = 2'b11; data_in = {32'h0000_9004, 32'h0000_9000};
    step();
    n_checks += 3;
    if (valid_a !== 2'b00) begin n_fail++; $display("FAIL flush_s0 valid_a got %b exp 00", valid_a); end
    if (count_a !== 16'd2) begin n_fail++; $display("FAIL flush_s0 count_a got %0d exp 2", count_a); end
    if (valid_b !== 2'b11) begin n_fail++; $display("FAIL flush_resume valid_b got %b exp 11", valid_b); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 40; c++)
      drive_sb(2'($urandom), ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
               {$urandom, $urandom}, "b2b");
  endtask

  task automatic test_saturation();
    logic [3:0] exp;
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      step();
      exp = (c > 15) ? 4'd15 : 4'(c);
      n_checks++;
      if (count_b !== exp) begin n_fail++; $display("FAIL saturate cycle %0d count_b got %0d exp %0d", c, count_b, exp); end
    end
    n_checks++;
    if (count_a !== 16'd20) begin n_fail++; $display("FAIL saturate count_a got %0d exp 20", count_a); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_reset_mid();
    test_latency();
    test_kill();
    test_stall();
    test_flush();
    test_back_to_back();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
